// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle: instruction-memory read channel plus the consumer handshake.
// Latency: none, this is a plain signal bundle with no logic.
// Backpressure: memAck stalls the read channel; instrReady stalls the consumer side.
interface pc_sequencer_if;
   logic       memReq;
   logic [7:0] memAddr;
   logic       memAck;
   logic [7:0] memData;
   logic       instrValid;
   logic [7:0] instr;
   logic [7:0] instrAddr;
   logic       instrReady;
   logic       redirect;
   logic [7:0] target;
   logic       callEn;
   logic       retEn;
   logic       halt;

   // Sequencer view: drives the read request and presents fetched instructions.
   modport master (
      output memReq, memAddr, instrValid, instr, instrAddr,
      input  memAck, memData, instrReady, redirect, target, callEn, retEn, halt
   );

   // Environment view: memory model plus instruction consumer.
   modport slave (
      input  memReq, memAddr, instrValid, instr, instrAddr,
      output memAck, memData, instrReady, redirect, target, callEn, retEn, halt
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches bytes, presents them, follows redirect/call/return/halt.
// Latency: one cycle in REQ (memAck permitting) plus one in HOLD (instrReady permitting) per fetch.
// Backpressure: memAddr is held until memAck; instr/instrAddr are held until instrReady.
module pc_sequencer #(
   parameter int STACK_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   pc_sequencer_if.master        bus,
   output logic                  halted,
   output logic                  stackErr
);

   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = $clog2(STACK_DEPTH);
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} state_t;

   state_t         state;
   state_t         stateNext;
   logic [7:0]     pc;
   logic [7:0]     pcNext;
   logic [7:0]     instrR;
   logic [7:0]     instrAddrR;
   logic [7:0]     stack [STACK_DEPTH];
   logic [SPW-1:0] sp;
   logic [SPW-1:0] spNext;
   logic [IW-1:0]  topIdx;
   logic [IW-1:0]  pushIdx;
   logic           push;
   logic           errSet;
   logic           fetchDone;

   // The return address always lives one slot below the pointer; pushes land at the pointer.
   assign topIdx    = IW'(sp - SP_ONE);
   assign pushIdx   = sp[IW-1:0];
   assign fetchDone = (state == REQ) && bus.memAck;

   assign bus.memReq     = (state == REQ);
   assign bus.memAddr    = pc;
   assign bus.instrValid = (state == HOLD);
   assign bus.instr      = instrR;
   assign bus.instrAddr  = instrAddrR;
   assign halted         = (state == HALTED);

   // State register; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Next-state and next-pc selection; control inputs only matter on the HOLD handshake.
   always_comb begin
      stateNext = state;
      pcNext    = pc;
      spNext    = sp;
      push      = 1'b0;
      errSet    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               stateNext = REQ;
               pcNext    = 8'h00;
            end
         end
         REQ: begin
            if (bus.memAck) stateNext = HOLD;
         end
         HOLD: begin
            if (bus.instrReady) begin
               if (bus.halt) begin
                  stateNext = HALTED;
               end else if (bus.retEn) begin
                  if (sp == '0) begin
                     errSet    = 1'b1;
                     stateNext = HALTED;
                  end else begin
                     spNext    = sp - SP_ONE;
                     pcNext    = stack[topIdx];
                     stateNext = REQ;
                  end
               end else if (bus.callEn) begin
                  if (sp == SP_FULL) begin
                     errSet    = 1'b1;
                     stateNext = HALTED;
                  end else begin
                     push      = 1'b1;
                     spNext    = sp + SP_ONE;
                     pcNext    = bus.target;
                     stateNext = REQ;
                  end
               end else if (bus.redirect) begin
                  pcNext    = bus.target;
                  stateNext = REQ;
               end else begin
                  // 8-bit add wraps 0xFF to 0x00 silently.
                  pcNext    = instrAddrR + 8'd1;
                  stateNext = REQ;
               end
            end
         end
         HALTED: begin
            stateNext = HALTED;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Datapath registers: pc, captured instruction, stack pointer and the sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= 8'h00;
         instrR     <= 8'h00;
         instrAddrR <= 8'h00;
         sp         <= '0;
         stackErr   <= 1'b0;
      end else begin
         pc <= pcNext;
         sp <= spNext;
         if (fetchDone) begin
            instrR     <= bus.memData;
            instrAddrR <= pc;
         end
         if (errSet) stackErr <= 1'b1;
      end
   end

   // Return-address storage; contents need no reset because the pointer gates every read.
   always_ff @(posedge clk) begin
      if (!reset && push) stack[pushIdx] <= instrAddrR + 8'd1;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a queue-based program-flow model.
// Latency: checks each fetch from request through handshake, including the 3-cycle span.
// Backpressure: drives random memAck/instrReady delays and ignored control noise.
module tb_pc_sequencer;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic halted;
   logic stackErr;

   pc_sequencer_if bus ();

   pc_sequencer #(.STACK_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus),
      .halted   (halted),
      .stackErr (stackErr)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   int nCmp = 0;
   int nBad = 0;

   // Reference model: program counter, return stack as a queue, halt/error flags.
   logic [7:0] mPc;
   logic [7:0] mStack [$];
   bit         mHalted;
   bit         mErr;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      if (obs !== exp) begin
         nBad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clearIn();
      bus.memAck     = 1'b0;
      bus.memData    = 8'h00;
      bus.instrReady = 1'b0;
      bus.redirect   = 1'b0;
      bus.callEn     = 1'b0;
      bus.retEn      = 1'b0;
      bus.halt       = 1'b0;
      bus.target     = 8'h00;
   endtask

   // Control inputs that must be ignored outside a handshake.
   task automatic noiseCtl();
      bus.redirect = 1'($urandom);
      bus.callEn   = 1'($urandom);
      bus.retEn    = 1'($urandom);
      bus.halt     = 1'($urandom);
      bus.target   = 8'($urandom);
   endtask

   task automatic doReset();
      clearIn();
      start = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      mPc = 8'h00;
      mStack.delete();
      mHalted = 1'b0;
      mErr = 1'b0;
      checkVal("rstMemReq",     32'(bus.memReq),     0);
      checkVal("rstInstrValid", 32'(bus.instrValid), 0);
      checkVal("rstHalted",     32'(halted),         0);
      checkVal("rstStackErr",   32'(stackErr),       0);
      checkVal("rstInstr",      32'(bus.instr),      0);
      checkVal("rstInstrAddr",  32'(bus.instrAddr),  0);
   endtask

   task automatic doStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mPc = 8'h00;
   endtask

   // One complete fetch: wait for REQ, ack after ackDly, accept after rdyDly with given controls.
   task automatic doFetch(input int ackDly, input int rdyDly, input bit hl, input bit re,
                          input bit ce, input bit rd, input logic [7:0] tgt, input bit noise,
                          output int reqCyc);
      int w;
      logic [7:0] d;
      logic [7:0] fetchAddr;
      clearIn();
      w = 0;
      reqCyc = cycle;
      while (!bus.memReq && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (!bus.memReq) begin
         checkVal("reqTimeout", 32'(bus.memReq), 1);
         return;
      end
      reqCyc = cycle;
      fetchAddr = mPc;
      checkVal("memAddr", 32'(bus.memAddr), 32'(fetchAddr));
      for (int i = 0; i < ackDly; i++) begin
         if (noise) begin
            noiseCtl();
            bus.instrReady = 1'($urandom);
         end
         @(negedge clk);
         checkVal("reqHold",    32'(bus.memReq),  1);
         checkVal("addrStable", 32'(bus.memAddr), 32'(fetchAddr));
      end
      clearIn();
      d = 8'($urandom);
      bus.memAck  = 1'b1;
      bus.memData = d;
      @(negedge clk);
      bus.memAck = 1'b0;
      checkVal("instrValid", 32'(bus.instrValid), 1);
      checkVal("instr",      32'(bus.instr),      32'(d));
      checkVal("instrAddr",  32'(bus.instrAddr),  32'(fetchAddr));
      checkVal("reqLowHold", 32'(bus.memReq),     0);
      for (int i = 0; i < rdyDly; i++) begin
         if (noise) begin
            noiseCtl();
            bus.memAck  = 1'($urandom);
            bus.memData = 8'($urandom);
         end
         bus.instrReady = 1'b0;
         @(negedge clk);
         checkVal("validStall",  32'(bus.instrValid), 1);
         checkVal("instrStable", 32'(bus.instr),      32'(d));
         checkVal("iaddrStable", 32'(bus.instrAddr),  32'(fetchAddr));
      end
      clearIn();
      bus.instrReady = 1'b1;
      bus.halt       = hl;
      bus.retEn      = re;
      bus.callEn     = ce;
      bus.redirect   = rd;
      bus.target     = tgt;
      @(negedge clk);
      clearIn();
      // Program-flow rules, highest priority first.
      if (hl) begin
         mHalted = 1'b1;
      end else if (re) begin
         if (mStack.size() == 0) begin
            mErr = 1'b1;
            mHalted = 1'b1;
         end else begin
            mPc = mStack.pop_back();
         end
      end else if (ce) begin
         if (mStack.size() == DEPTH) begin
            mErr = 1'b1;
            mHalted = 1'b1;
         end else begin
            mStack.push_back(fetchAddr + 8'd1);
            mPc = tgt;
         end
      end else if (rd) begin
         mPc = tgt;
      end else begin
         mPc = fetchAddr + 8'd1;
      end
      checkVal("halted",   32'(halted),   32'(mHalted));
      checkVal("stackErr", 32'(stackErr), 32'(mErr));
      if (!mHalted) begin
         checkVal("nextReq",  32'(bus.memReq),  1);
         checkVal("nextAddr", 32'(bus.memAddr), 32'(mPc));
      end else begin
         checkVal("haltNoReq",   32'(bus.memReq),     0);
         checkVal("haltNoValid", 32'(bus.instrValid), 0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, c2, c3;
      clearIn();
      @(negedge clk);
      doReset();

      // Sequential fetch 0x00..0x02 at full rate.
      doStart();
      doFetch(0, 0, 0, 0, 0, 0, 8'h00, 0, c0);
      doFetch(0, 0, 0, 0, 0, 0, 8'h00, 0, c1);
      doFetch(0, 0, 0, 0, 0, 0, 8'h00, 0, c2);
      checkVal("span01", 32'(c1 - c0 + 1), 3);
      checkVal("span12", 32'(c2 - c1 + 1), 3);

      // Redirect to 0xFF, stall the consumer 5 cycles, then wrap to 0x00.
      doFetch(0, 0, 0, 0, 0, 1, 8'hFF, 0, c3);
      doFetch(1, 5, 0, 0, 0, 0, 8'h00, 1, c3);
      checkVal("wrapAddr", 32'(bus.memAddr), 0);

      // Call from 0x10 to 0x40, return to 0x11.
      doFetch(0, 0, 0, 0, 0, 1, 8'h10, 0, c3);
      doFetch(0, 0, 0, 0, 1, 0, 8'h40, 0, c3);
      checkVal("callAddr", 32'(bus.memAddr), 32'h40);
      doFetch(2, 1, 0, 1, 0, 0, 8'h00, 1, c3);
      checkVal("retAddr", 32'(bus.memAddr), 32'h11);

      // Everything asserted at once: halt wins, no stack error, start ignored.
      doFetch(0, 0, 1, 1, 1, 1, 8'h77, 0, c3);
      checkVal("prioHalted", 32'(halted),   1);
      checkVal("prioErr",    32'(stackErr), 0);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      checkVal("haltStart", 32'(bus.memReq), 0);
      checkVal("haltStays", 32'(halted),     1);

      // Five nested calls overflow a depth-4 stack.
      doReset();
      doStart();
      for (int i = 0; i < 4; i++) doFetch(0, 0, 0, 0, 1, 0, 8'(8'h20 + 8'(i * 16)), 0, c3);
      checkVal("noErrYet", 32'(stackErr), 0);
      doFetch(0, 0, 0, 0, 1, 0, 8'h90, 0, c3);
      checkVal("ovfErr",    32'(stackErr), 1);
      checkVal("ovfHalted", 32'(halted),   1);

      // Return with an empty stack.
      doReset();
      doStart();
      doFetch(0, 0, 0, 1, 0, 0, 8'h00, 0, c3);
      checkVal("unfErr",    32'(stackErr), 1);
      checkVal("unfHalted", 32'(halted),   1);

      // Reset in REQ together with memAck: the ack is discarded.
      doReset();
      doStart();
      checkVal("midReq", 32'(bus.memReq), 1);
      bus.memAck  = 1'b1;
      bus.memData = 8'hAA;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      clearIn();
      checkVal("midRstReq",   32'(bus.memReq),     0);
      checkVal("midRstValid", 32'(bus.instrValid), 0);
      checkVal("midRstInstr", 32'(bus.instr),      0);
      @(negedge clk);
      checkVal("midRstIdle", 32'(bus.memReq), 0);
      mPc = 8'h00;
      mStack.delete();
      mHalted = 1'b0;
      mErr = 1'b0;
      doStart();
      doFetch(0, 0, 0, 0, 0, 0, 8'h00, 0, c3);

      // Randomized program flow.
      for (int n = 0; n < 400; n++) begin
         if (mHalted) begin
            repeat (2) @(negedge clk);
            checkVal("rndHaltIdle", 32'(bus.memReq), 0);
            doReset();
            doStart();
         end
         doFetch($urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                 8'($urandom), 1'($urandom), c3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
